// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, sequencer
// states, instruction classes and the datapath strobe bundle.
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I,
        CLS_BR, CLS_JR, CLS_NOP, CLS_HALT, CLS_ILL
    } iclass_t;

    // One bit per datapath strobe, in port order.
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic write;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic ba_out;
        logic con_in;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction-class decode; anything unlisted is classed illegal.
module cu_decode
    import mini_src_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output iclass_t          iclass_c
);

    always_comb begin
        iclass_c = CLS_ILL;
        case (opcode)
            OPC_W'(OP_LD):   iclass_c = CLS_LD;
            OPC_W'(OP_LDI):  iclass_c = CLS_LDI;
            OPC_W'(OP_ST):   iclass_c = CLS_ST;
            OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_SHR), OPC_W'(OP_SHL),
            OPC_W'(OP_ROR), OPC_W'(OP_ROL), OPC_W'(OP_AND), OPC_W'(OP_OR):
                             iclass_c = CLS_ALU_R;
            OPC_W'(OP_ADDI), OPC_W'(OP_ANDI), OPC_W'(OP_ORI):
                             iclass_c = CLS_ALU_I;
            OPC_W'(OP_BR):   iclass_c = CLS_BR;
            OPC_W'(OP_JR):   iclass_c = CLS_JR;
            OPC_W'(OP_NOP):  iclass_c = CLS_NOP;
            OPC_W'(OP_HALT): iclass_c = CLS_HALT;
            default:         iclass_c = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch, decode and the
// per-instruction T3-T7 strobe sequence, with optional memory wait states.
module control_sequencer
    import mini_src_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 0,
    parameter int unsigned OPC_W           = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    output logic        PC_out,
    output logic        PC_in,
    output logic        IncPC,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        Read,
    output logic        Write,
    output logic        C_out,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_in,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    localparam int unsigned WAIT_W = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [OPC_W-1:0]  opcode;
    iclass_t           iclass_c;
    logic              mem_state_c;
    logic              mem_hold_c;
    logic              unused_ir;
    ctrl_t             ctrl_c;
    logic [4:0]        alu_op_c;
    logic              run_c;
    logic              illegal_c;

    // IR is stable from T3 until the next fetch, so decoding it live is safe.
    assign opcode    = IR_Data[31 -: OPC_W];
    assign unused_ir = ^IR_Data[31-OPC_W:0];

    cu_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode   (opcode),
        .iclass_c (iclass_c)
    );

    assign mem_state_c = (state == ST_T1)
                      || (state == ST_T6 && iclass_c == CLS_LD)
                      || (state == ST_T7 && iclass_c == CLS_ST);
    assign mem_hold_c  = mem_state_c && (wait_cnt != WAIT_W'(MEM_WAIT_CYCLES));

    // State register and wait counter; a held memory state only advances the counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_RST;
            wait_cnt <= '0;
        end else if (mem_hold_c) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
            case (state)
                ST_RST:  state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3: begin
                    case (iclass_c)
                        CLS_HALT:                    state <= ST_HALT;
                        CLS_JR, CLS_NOP, CLS_ILL:    state <= ST_T0;
                        default:                     state <= ST_T4;
                    endcase
                end
                ST_T4:   state <= ST_T5;
                ST_T5: begin
                    if (iclass_c == CLS_LD || iclass_c == CLS_ST || iclass_c == CLS_BR)
                        state <= ST_T6;
                    else
                        state <= ST_T0;
                end
                ST_T6: begin
                    if (iclass_c == CLS_LD || iclass_c == CLS_ST)
                        state <= ST_T7;
                    else
                        state <= ST_T0;
                end
                ST_T7:   state <= ST_T0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Strobe decode of the current state (plus instruction class and, in br-T6, CON_out).
    always_comb begin
        ctrl_c    = '0;
        alu_op_c  = '0;
        run_c     = 1'b1;
        illegal_c = 1'b0;
        case (state)
            ST_T0: begin
                ctrl_c.pc_out = 1'b1; ctrl_c.mar_in = 1'b1;
                ctrl_c.inc_pc = 1'b1; ctrl_c.z_in   = 1'b1;
            end
            ST_T1: begin
                ctrl_c.zlow_out = 1'b1; ctrl_c.pc_in  = 1'b1;
                ctrl_c.read     = 1'b1; ctrl_c.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl_c.mdr_out = 1'b1; ctrl_c.ir_in = 1'b1;
            end
            ST_T3: begin
                case (iclass_c)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_c.grb = 1'b1; ctrl_c.ba_out = 1'b1; ctrl_c.y_in = 1'b1;
                    end
                    CLS_ALU_R, CLS_ALU_I: begin
                        ctrl_c.grb = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.y_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_c.gra = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        ctrl_c.gra = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.pc_in = 1'b1;
                    end
                    CLS_ILL: illegal_c = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (iclass_c)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_c.c_out = 1'b1; ctrl_c.z_in = 1'b1; alu_op_c = OP_ADD;
                    end
                    CLS_ALU_R: begin
                        ctrl_c.grc = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.z_in = 1'b1;
                        alu_op_c = 5'(opcode);
                    end
                    CLS_ALU_I: begin
                        ctrl_c.c_out = 1'b1; ctrl_c.z_in = 1'b1; alu_op_c = 5'(opcode);
                    end
                    CLS_BR: begin
                        ctrl_c.pc_out = 1'b1; ctrl_c.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (iclass_c)
                    CLS_LD, CLS_ST: begin
                        ctrl_c.zlow_out = 1'b1; ctrl_c.mar_in = 1'b1;
                    end
                    CLS_LDI, CLS_ALU_R, CLS_ALU_I: begin
                        ctrl_c.zlow_out = 1'b1; ctrl_c.gra = 1'b1; ctrl_c.rin = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_c.c_out = 1'b1; ctrl_c.z_in = 1'b1; alu_op_c = OP_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (iclass_c)
                    CLS_LD: begin
                        ctrl_c.read = 1'b1; ctrl_c.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl_c.gra = 1'b1; ctrl_c.rout = 1'b1; ctrl_c.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_c.zlow_out = CON_out; ctrl_c.pc_in = CON_out;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (iclass_c)
                    CLS_LD: begin
                        ctrl_c.mdr_out = 1'b1; ctrl_c.gra = 1'b1; ctrl_c.rin = 1'b1;
                    end
                    CLS_ST:  ctrl_c.write = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: run_c = 1'b0;
            default: ;
        endcase
    end

    assign {PC_out, PC_in, IncPC, IR_in, Y_in, Z_in, Zlow_out, MAR_in, MDR_in, MDR_out,
            Read, Write, C_out, Gra, Grb, Grc, Rin, Rout, BAout, CON_in} = ctrl_c;
    assign alu_op  = alu_op_c;
    assign run     = run_c;
    assign illegal = illegal_c;

endmodule
